// File: rtl/slip_tx_arbiter.sv
`timescale 1ns/1ps
// slip_tx_arbiter
// Frame-level round-robin arbiter that shares one slip_escaper input among
// NUM_CH framed symbol sources. Each granted frame goes out as:
//   START mark, channel-ID symbol (CH_ID_BASE + channel), payload, END mark.
// Payload is passed through untouched; escaping is the escaper's job.
//
// Handshake: every s_* and m_* port is AXIS-like. A symbol moves on a rising
// clk edge where valid && ready are both high. A producer holds its data
// stable while valid && !ready. Ready never depends on the same side's valid,
// except in PAY, where s_ready[grant] is a straight copy of m_ready.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   s_data     packed payload buses, channel k at [k*SYMBOL_WIDTH +: SYMBOL_WIDTH]
//   s_last     per-channel last-symbol-of-frame flag
//   s_valid    per-channel valid
//   s_ready    per-channel ready (only the granted channel, only in PAY)
//   m_data     symbol to the escaper
//   m_mark     marker flag to the escaper
//   m_valid    output valid
//   m_ready    escaper ready
//   o_grant    currently or most recently granted channel
//   o_busy     high in every state except IDLE
//   dbg_state  FSM state, for checkers and debug
module slip_tx_arbiter #(
  parameter int                      SYMBOL_WIDTH = 8,
  parameter int                      NUM_CH       = 2,
  parameter logic [SYMBOL_WIDTH-1:0] CH_ID_BASE   = SYMBOL_WIDTH'(1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_CH*SYMBOL_WIDTH-1:0]           s_data,
  input  logic [NUM_CH-1:0]                        s_last,
  input  logic [NUM_CH-1:0]                        s_valid,
  output logic [NUM_CH-1:0]                        s_ready,
  output logic [SYMBOL_WIDTH-1:0]                  m_data,
  output logic                                     m_mark,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [$clog2(NUM_CH > 2 ? NUM_CH : 2)-1:0] o_grant,
  output logic                                     o_busy,
  output logic [2:0]                               dbg_state
);

  localparam int GW   = $clog2(NUM_CH > 2 ? NUM_CH : 2);
  localparam int IDXW = GW + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_HDR   = 3'd2;
  localparam logic [2:0] ST_PAY   = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

  logic [2:0]    state;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_ptr;

  // Round-robin search: first requester at rr_ptr, rr_ptr+1, ... mod NUM_CH.
  logic [IDXW-1:0] idx;
  logic [GW-1:0]   pick;
  logic            found;

  always_comb begin
    idx   = '0;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_ptr} + IDXW'(i);
      if (idx >= IDXW'(NUM_CH)) idx = idx - IDXW'(NUM_CH);
      if (!found && s_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant <= pick;
            state <= ST_START;
          end
        end
        ST_START: if (m_ready) state <= ST_HDR;
        ST_HDR:   if (m_ready) state <= ST_PAY;
        ST_PAY: begin
          if (s_valid[grant] && m_ready && s_last[grant]) state <= ST_END;
        end
        ST_END: begin
          if (m_ready) begin
            state  <= ST_IDLE;
            // Next search starts just past the channel that was served.
            rr_ptr <= (grant == GW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // START/HDR/END outputs come from registers only, so they hold under
  // backpressure. PAY is a combinational pass-through of the granted channel.
  always_comb begin
    m_data  = '0;
    m_mark  = 1'b0;
    m_valid = 1'b0;
    s_ready = '0;
    case (state)
      ST_START: begin
        m_valid = 1'b1;
        m_mark  = 1'b1;
      end
      ST_HDR: begin
        m_valid = 1'b1;
        m_data  = CH_ID_BASE + SYMBOL_WIDTH'(grant);
      end
      ST_PAY: begin
        m_valid        = s_valid[grant];
        m_data         = s_data[grant*SYMBOL_WIDTH +: SYMBOL_WIDTH];
        s_ready[grant] = m_ready;
      end
      ST_END: begin
        m_valid = 1'b1;
        m_mark  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_grant   = grant;
  assign o_busy    = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_slip_tx_arbiter.sv
`timescale 1ns/1ps
// Directed bench for slip_tx_arbiter (NUM_CH=2, SYMBOL_WIDTH=8, CH_ID_BASE=01).
// Sources are per-channel queues of {last, data}; expected output symbols are
// {mark, data} entries in exp_q, written by hand for each frame.
module tb_slip_tx_arbiter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic [1:0]  s_last;
  logic [1:0]  s_valid;
  logic [1:0]  s_ready;
  logic [7:0]  m_data;
  logic        m_mark;
  logic        m_valid;
  logic        m_ready;
  logic [0:0]  o_grant;
  logic        o_busy;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  slip_tx_arbiter #(.SYMBOL_WIDTH(8), .NUM_CH(2), .CH_ID_BASE(8'h01)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_mark(m_mark), .m_valid(m_valid), .m_ready(m_ready),
    .o_grant(o_grant), .o_busy(o_busy), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  int         vectors     = 0;
  int         miscompares = 0;
  int         busy_cnt;
  int         sym_cnt;
  int         run_cyc;
  bit         chk_ready;
  bit         toggle_ready;
  bit         prev_stall;
  logic [8:0] prev_sym;
  logic [1:0] ch_en;
  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];
  logic [8:0] exp_q[$];

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply();
    s_valid[0]  = ch_en[0] && (src_q0.size() != 0);
    s_data[7:0] = (src_q0.size() != 0) ? src_q0[0][7:0] : 8'h00;
    s_last[0]   = (src_q0.size() != 0) ? src_q0[0][8] : 1'b0;
    s_valid[1]  = ch_en[1] && (src_q1.size() != 0);
    s_data[15:8] = (src_q1.size() != 0) ? src_q1[0][7:0] : 8'h00;
    s_last[1]   = (src_q1.size() != 0) ? src_q1[0][8] : 1'b0;
  endtask

  // One clock: drive, settle, check what will transfer on the coming edge.
  task automatic step();
    logic [8:0] cur;
    apply();
    #1;
    cur = {m_mark, m_data};
    if (chk_ready) begin
      chk("s_ready_grant", {15'd0, s_ready[1]},
          {15'd0, m_ready && (sym_cnt >= 2) && (sym_cnt <= 5)});
      chk("s_ready_other", {15'd0, s_ready[0]}, 16'd0);
    end
    if (prev_stall && m_valid) chk("stall_hold", {7'd0, cur}, {7'd0, prev_sym});
    if (m_valid === 1'b1 && m_ready) begin
      if (exp_q.size() == 0) chk("unexpected_symbol", {15'd0, m_valid}, 16'd0);
      else chk("stream_symbol", {7'd0, cur}, {7'd0, exp_q.pop_front()});
      sym_cnt++;
    end
    prev_stall = m_valid && !m_ready;
    prev_sym   = cur;
    busy_cnt  += int'(o_busy);
    if (s_valid[0] && s_ready[0]) void'(src_q0.pop_front());
    if (s_valid[1] && s_ready[1]) void'(src_q1.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int max_cyc);
    run_cyc = 0;
    while (exp_q.size() != 0 && run_cyc < max_cyc) begin
      if (toggle_ready) m_ready = ~m_ready;
      step();
      run_cyc++;
    end
    if (exp_q.size() != 0) chk("timeout_pending", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q0.delete();
    src_q1.delete();
    exp_q.delete();
    apply();
    #1;
    chk("reset_m_valid", {15'd0, m_valid}, 16'd0);
    chk("reset_busy", {15'd0, o_busy}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    prev_stall = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; m_ready = 1'b0; ch_en = 2'b11;
    chk_ready = 1'b0; toggle_ready = 1'b0; prev_stall = 1'b0; prev_sym = '0;
    busy_cnt = 0; sym_cnt = 0; run_cyc = 0;
    s_data = '0; s_last = '0; s_valid = '0;
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", {15'd0, m_valid}, 16'd0);
    chk("rst_m_mark",  {15'd0, m_mark}, 16'd0);
    chk("rst_m_data",  {8'd0, m_data}, 16'd0);
    chk("rst_s_ready", {14'd0, s_ready}, 16'd0);
    chk("rst_o_grant", {15'd0, o_grant}, 16'd0);
    chk("rst_o_busy",  {15'd0, o_busy}, 16'd0);
    chk("rst_state",   {13'd0, dbg_state}, 16'd0);
    rst = 1'b0;

    // Basic ch0 frame A1,B2,C3 with m_ready held high.
    m_ready = 1'b1;
    src_q0 = '{9'h0A1, 9'h0B2, 9'h1C3};
    exp_q  = '{9'h100, 9'h001, 9'h0A1, 9'h0B2, 9'h0C3, 9'h100};
    busy_cnt = 0;
    run(20);
    chk("frame_cycles", 16'(run_cyc), 16'd7);
    chk("busy_cycles", 16'(busy_cnt), 16'd6);
    apply(); #1;
    chk("idle_after_end_busy", {15'd0, o_busy}, 16'd0);
    chk("idle_after_end_valid", {15'd0, m_valid}, 16'd0);

    // Both channels requesting from reset: ch0, ch1, then ch0 again.
    do_reset();
    src_q0 = '{9'h011, 9'h112, 9'h031, 9'h132};
    src_q1 = '{9'h021, 9'h122};
    exp_q  = '{9'h100, 9'h001, 9'h011, 9'h012, 9'h100,
               9'h100, 9'h002, 9'h021, 9'h022, 9'h100,
               9'h100, 9'h001, 9'h031, 9'h032, 9'h100};
    run(60);

    // Escapable payload values pass unmodified, nothing inserted.
    src_q0 = '{9'h0C0, 9'h1DB};
    exp_q  = '{9'h100, 9'h001, 9'h0C0, 9'h0DB, 9'h100};
    run(20);
    repeat (3) step();
    chk("no_extra_valid", {15'd0, m_valid}, 16'd0);

    // Backpressure 1010... across a 4-symbol ch1 frame.
    src_q1 = '{9'h044, 9'h055, 9'h066, 9'h177};
    exp_q  = '{9'h100, 9'h002, 9'h044, 9'h055, 9'h066, 9'h077, 9'h100};
    sym_cnt = 0; chk_ready = 1'b1; toggle_ready = 1'b1; m_ready = 1'b0;
    run(40);
    chk("toggle_sym_count", 16'(sym_cnt), 16'd7);
    chk_ready = 1'b0; toggle_ready = 1'b0; m_ready = 1'b1;

    // ch1 bubble of 3 cycles while ch0 waits.
    src_q1 = '{9'h081, 9'h082, 9'h183};
    exp_q  = '{9'h100, 9'h002, 9'h081, 9'h082, 9'h083, 9'h100,
               9'h100, 9'h001, 9'h091, 9'h092, 9'h100};
    step();
    src_q0 = '{9'h091, 9'h192};
    repeat (3) step();
    ch_en[1] = 1'b0;
    repeat (3) begin
      apply(); #1;
      chk("bubble_m_valid", {15'd0, m_valid}, 16'd0);
      chk("bubble_s_ready0", {15'd0, s_ready[0]}, 16'd0);
      chk("bubble_grant", {15'd0, o_grant}, 16'd1);
      step();
    end
    ch_en[1] = 1'b1;
    run(40);

    // Reset in the middle of a ch1 payload.
    src_q1 = '{9'h0A5, 9'h0A6, 9'h1A7};
    exp_q  = '{9'h100, 9'h002, 9'h0A5};
    repeat (4) step();
    chk("pre_reset_pending", 16'(exp_q.size()), 16'd0);
    chk("pre_reset_grant", {15'd0, o_grant}, 16'd1);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", {15'd0, m_valid}, 16'd0);
    chk("midrst_s_ready", {14'd0, s_ready}, 16'd0);
    chk("midrst_o_grant", {15'd0, o_grant}, 16'd0);
    chk("midrst_o_busy", {15'd0, o_busy}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_stall = 1'b0;
    exp_q = '{9'h100, 9'h002, 9'h0A6, 9'h0A7, 9'h100};
    run(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
